// File: rtl/id_stage.sv
// Decode stage: owns the register file, resolves branches/jumps in ID, detects
// load-use and branch-operand hazards, and registers operands/control into ID/EX.
module id_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_PC,
    input  logic [31:0] IF_ID_Instruction,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_Rd,
    input  logic [31:0] WB_Data,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_Rd,
    output logic        PCWrite,
    output logic        IF_ID_WriteEnable,
    output logic        BranchTaken,
    output logic        PCSrc,
    output logic [31:0] branchTarget,
    output logic [31:0] ID_EX_PC,
    output logic [31:0] ID_EX_ReadData1,
    output logic [31:0] ID_EX_ReadData2,
    output logic [31:0] ID_EX_Imm,
    output logic [4:0]  ID_EX_Rs,
    output logic [4:0]  ID_EX_Rt,
    output logic [4:0]  ID_EX_Rd,
    output logic [2:0]  ID_EX_ALUOp,
    output logic        ID_EX_ALUSrc,
    output logic        ID_EX_MemRead,
    output logic        ID_EX_MemWrite,
    output logic        ID_EX_RegWrite,
    output logic        ID_EX_MemToReg
);

    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];
    logic        squash_q, squash_d;

    logic [31:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [4:0]  rs_q, rs_d, rt_q, rt_d, rdst_q, rdst_d;
    logic [2:0]  aluop_q, aluop_d;
    logic        alusrc_q, alusrc_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic        regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext, rd1, rd2;
    logic        r_ok;
    logic [2:0]  r_aluop;
    logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_branch, is_valid;
    logic        uses_rs, uses_rt;
    logic        load_use, br_haz, stall, taken;

    assign op       = IF_ID_Instruction[31:26];
    assign rs       = IF_ID_Instruction[25:21];
    assign rt       = IF_ID_Instruction[20:16];
    assign rd       = IF_ID_Instruction[15:11];
    assign funct    = IF_ID_Instruction[5:0];
    assign imm_sext = {{16{IF_ID_Instruction[15]}}, IF_ID_Instruction[15:0]};

    // Register read with write-through bypass from WB
    assign rd1 = (rs == 5'd0) ? 32'd0 :
                 (WB_RegWrite && WB_Rd == rs) ? WB_Data : rf_q[rs];
    assign rd2 = (rt == 5'd0) ? 32'd0 :
                 (WB_RegWrite && WB_Rd == rt) ? WB_Data : rf_q[rt];

    always_comb begin
        r_ok    = 1'b1;
        r_aluop = 3'b000;
        case (funct)
            6'b100000: r_aluop = 3'b000;
            6'b100010: r_aluop = 3'b001;
            6'b100100: r_aluop = 3'b010;
            6'b100101: r_aluop = 3'b011;
            6'b101010: r_aluop = 3'b100;
            default:   r_ok    = 1'b0;
        endcase
    end

    // A squashed (wrong-path) instruction decodes as nothing at all
    assign is_r      = !squash_q && op == 6'b000000 && r_ok;
    assign is_addi   = !squash_q && op == 6'b001000;
    assign is_lw     = !squash_q && op == 6'b100011;
    assign is_sw     = !squash_q && op == 6'b101011;
    assign is_beq    = !squash_q && op == 6'b000100;
    assign is_bne    = !squash_q && op == 6'b000101;
    assign is_j      = !squash_q && op == 6'b000010;
    assign is_branch = is_beq | is_bne;
    assign is_valid  = is_r | is_addi | is_lw | is_sw | is_branch | is_j;
    assign uses_rs   = is_r | is_addi | is_lw | is_sw | is_branch;
    assign uses_rt   = is_r | is_sw | is_branch;

    assign load_use = memread_q && rdst_q != 5'd0 &&
                      ((uses_rs && rs == rdst_q) || (uses_rt && rt == rdst_q));
    // No forwarding into ID, so branch operands must wait for EX and MEM producers
    assign br_haz = is_branch && (
        (rs != 5'd0 && ((regwrite_q && rs == rdst_q) || (MEM_RegWrite && rs == MEM_Rd))) ||
        (rt != 5'd0 && ((regwrite_q && rt == rdst_q) || (MEM_RegWrite && rt == MEM_Rd))));
    assign stall = load_use | br_haz;

    assign taken = !stall && (is_j || (is_beq && rd1 == rd2) || (is_bne && rd1 != rd2));

    assign PCWrite           = !stall;
    assign IF_ID_WriteEnable = !stall;
    assign BranchTaken       = taken;
    assign PCSrc             = taken;
    assign branchTarget      = !taken ? IF_ID_PC :
                               is_j   ? {IF_ID_PC[31:26], IF_ID_Instruction[25:0]} :
                                        IF_ID_PC + imm_sext;

    always_comb begin
        rf_d = rf_q;
        if (WB_RegWrite && WB_Rd != 5'd0) rf_d[WB_Rd] = WB_Data;
        squash_d = taken;
    end

    always_comb begin
        pc_d = '0; rd1_d = '0; rd2_d = '0; imm_d = '0;
        rs_d = '0; rt_d = '0; rdst_d = '0; aluop_d = '0;
        alusrc_d = 1'b0; memread_d = 1'b0; memwrite_d = 1'b0;
        regwrite_d = 1'b0; memtoreg_d = 1'b0;
        if (!stall && is_valid) begin
            pc_d       = IF_ID_PC;
            rd1_d      = rd1;
            rd2_d      = rd2;
            imm_d      = imm_sext;
            rs_d       = rs;
            rt_d       = rt;
            rdst_d     = is_r ? rd : rt;
            aluop_d    = is_r ? r_aluop : (is_branch ? 3'b001 : 3'b000);
            alusrc_d   = is_addi | is_lw | is_sw;
            memread_d  = is_lw;
            memwrite_d = is_sw;
            regwrite_d = is_r | is_addi | is_lw;
            memtoreg_d = is_lw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            squash_q <= 1'b0;
            pc_q <= '0; rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
            rs_q <= '0; rt_q <= '0; rdst_q <= '0; aluop_q <= '0;
            alusrc_q <= 1'b0; memread_q <= 1'b0; memwrite_q <= 1'b0;
            regwrite_q <= 1'b0; memtoreg_q <= 1'b0;
        end else begin
            rf_q     <= rf_d;
            squash_q <= squash_d;
            pc_q <= pc_d; rd1_q <= rd1_d; rd2_q <= rd2_d; imm_q <= imm_d;
            rs_q <= rs_d; rt_q <= rt_d; rdst_q <= rdst_d; aluop_q <= aluop_d;
            alusrc_q <= alusrc_d; memread_q <= memread_d; memwrite_q <= memwrite_d;
            regwrite_q <= regwrite_d; memtoreg_q <= memtoreg_d;
        end
    end

    assign ID_EX_PC        = pc_q;
    assign ID_EX_ReadData1 = rd1_q;
    assign ID_EX_ReadData2 = rd2_q;
    assign ID_EX_Imm       = imm_q;
    assign ID_EX_Rs        = rs_q;
    assign ID_EX_Rt        = rt_q;
    assign ID_EX_Rd        = rdst_q;
    assign ID_EX_ALUOp     = aluop_q;
    assign ID_EX_ALUSrc    = alusrc_q;
    assign ID_EX_MemRead   = memread_q;
    assign ID_EX_MemWrite  = memwrite_q;
    assign ID_EX_RegWrite  = regwrite_q;
    assign ID_EX_MemToReg  = memtoreg_q;

endmodule
